// File: rtl/id_ex_skid_stage.sv
// -----------------------------------------------------------------------------
// id_ex_skid_stage
//
// Decode-to-execute pipeline stage with a valid/ready handshake on both sides,
// a synchronous flush and a two-entry skid buffer (main + skid). The main
// entry drives the execute-side outputs; the skid entry absorbs the one beat
// that decode may push in the cycle before in_ready drops, so in_ready can be
// a pure register output and the execute stall never reaches decode
// combinationally.
//
// Optional feature macro: IDEX_PERF_CNT_EN
//   When defined, adds saturating 32-bit counters stall_cnt and flush_cnt.
//   When undefined, those ports and counters do not exist.
//
// Parameters:
//   XLEN    - width of PC+4, immediate and each source operand
//   CTRL_W  - width of the packed control bundle
//   NUM_SRC - number of source operands carried
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-low reset
//   flush         in   kill all held and incoming beats this cycle
//   in_valid      in   decode presents a beat
//   in_ready      out  stage can accept a beat (registered)
//   in_pc_plus_4  in   PC+4 of the decoded instruction
//   in_ctrl       in   packed control bundle
//   in_imm        in   immediate
//   in_src        in   source operands, operand 0 in the LSBs
//   out_valid     out  execute-side beat valid
//   out_ready     in   execute consumes the beat
//   out_pc_plus_4 out  held PC+4
//   out_ctrl      out  held control, forced to 0 while out_valid is 0
//   out_imm       out  held immediate
//   out_src       out  held operands
//   stall_cnt     out  (IDEX_PERF_CNT_EN) cycles with out_valid & ~out_ready
//   flush_cnt     out  (IDEX_PERF_CNT_EN) flushes that hit a non-empty stage
// -----------------------------------------------------------------------------
module id_ex_skid_stage #(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 24,
    parameter int NUM_SRC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc_plus_4,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [NUM_SRC*XLEN-1:0] in_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc_plus_4,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [XLEN-1:0]         out_imm,
    output logic [NUM_SRC*XLEN-1:0] out_src
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             flush_cnt
`endif
);

    localparam int SRC_W = NUM_SRC * XLEN;
    localparam int PAY_W = XLEN + CTRL_W + XLEN + SRC_W;

    // Payload packing: {pc_plus_4, ctrl, imm, src}
    logic [PAY_W-1:0] w_in_pay;
    logic [PAY_W-1:0] r_main_pay;
    logic [PAY_W-1:0] r_skid_pay;
    logic             r_main_valid;
    logic             r_skid_valid;

    logic w_accept;
    logic w_consume;
    logic w_main_valid_nxt;
    logic w_skid_valid_nxt;
    logic w_main_load_in;
    logic w_main_load_skid;
    logic w_skid_load;

    assign w_in_pay = {in_pc_plus_4, in_ctrl, in_imm, in_src};

    // in_ready comes straight from the skid valid flop: no input reaches it
    // in the same cycle.
    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;

    assign w_accept  = in_valid & ~r_skid_valid;
    assign w_consume = r_main_valid & out_ready;

    // Placement/advance decisions. The skid entry can only be valid while the
    // main entry is valid, so an empty main implies an empty skid.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_load_in   = 1'b0;
        w_main_load_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush) begin
            // Flush wins over accept and consume; the offered beat is dropped.
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid) begin
            w_main_valid_nxt = w_accept;
            w_main_load_in   = w_accept;
        end else if (w_consume) begin
            if (r_skid_valid) begin
                // Skid advances into main; an accept cannot happen here
                // because in_ready is low while skid is valid.
                w_main_load_skid = 1'b1;
                w_skid_valid_nxt = w_accept;
                w_skid_load      = w_accept;
            end else begin
                w_main_valid_nxt = w_accept;
                w_main_load_in   = w_accept;
            end
        end else if (w_accept) begin
            // Main is held: the beat parks in skid and in_ready drops next cycle.
            w_skid_valid_nxt = 1'b1;
            w_skid_load      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_pay   <= '0;
            r_skid_pay   <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_main_load_in) begin
                r_main_pay <= w_in_pay;
            end else if (w_main_load_skid) begin
                r_main_pay <= r_skid_pay;
            end
            if (w_skid_load) begin
                r_skid_pay <= w_in_pay;
            end
        end
    end

    logic [CTRL_W-1:0] w_main_ctrl;

    assign out_pc_plus_4 = r_main_pay[PAY_W-1 -: XLEN];
    assign w_main_ctrl   = r_main_pay[XLEN+SRC_W +: CTRL_W];
    assign out_imm       = r_main_pay[SRC_W +: XLEN];
    assign out_src       = r_main_pay[SRC_W-1:0];

    // Bubbles must look like NOPs downstream, so control is masked.
    assign out_ctrl = r_main_valid ? w_main_ctrl : '0;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_main_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush && (r_main_valid || r_skid_valid) &&
                (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
module tb_id_ex_skid_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [23:0] ctrl;
        logic [31:0] imm;
        logic [63:0] src;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc_plus_4;
    logic [23:0] in_ctrl;
    logic [31:0] in_imm;
    logic [63:0] in_src;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc_plus_4;
    logic [23:0] out_ctrl;
    logic [31:0] out_imm;
    logic [63:0] out_src;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    id_ex_skid_stage #(.XLEN(32), .CTRL_W(24), .NUM_SRC(2)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc_plus_4(in_pc_plus_4),
        .in_ctrl(in_ctrl),
        .in_imm(in_imm),
        .in_src(in_src),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc_plus_4(out_pc_plus_4),
        .out_ctrl(out_ctrl),
        .out_imm(out_imm),
        .out_src(out_src)
`ifdef IDEX_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    beat_t q[$];
    int    tests    = 0;
    int    fails    = 0;
    int    n_popped = 0;
    int    last_wait;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] pc);
        beat_t b;
        b.pc   = pc;
        b.ctrl = {8'h5A, pc[15:0]};
        b.imm  = pc ^ 32'h0000_5500;
        b.src  = {pc + 32'h2000, pc + 32'h1000};
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_pc_plus_4 = b.pc;
        in_ctrl      = b.ctrl;
        in_imm       = b.imm;
        in_src       = b.src;
        in_valid     = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input beat_t b);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        drive(b);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && !flush) q.push_back(b);
            @(posedge clk);
            #1;
            if (!acc) n++;
        end
        last_wait = n;
        in_valid  = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL send_timeout: pc 0x%0h not accepted after %0d cycles", b.pc, n);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every consumed beat must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            beat_t act;
            beat_t exp;
            act = {out_pc_plus_4, out_ctrl, out_imm, out_src};
            tests++;
            n_popped++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got pc 0x%0h with no beat expected", act.pc);
            end else begin
                exp = q.pop_front();
                if (act !== exp) begin
                    fails++;
                    $display("FAIL beat_mismatch: got %h expected %h", act, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int stalls;
        beat_t b;

        rst          = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_pc_plus_4 = '0;
        in_ctrl      = '0;
        in_imm       = '0;
        in_src       = '0;

        // Reset with a beat offered
        in_valid = 1'b1;
        in_ctrl  = 24'hABCDE;
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_ctrl", out_ctrl, 0);
            check("rst_in_ready", in_ready, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        cycles(1);

        b.pc   = 32'h104;
        b.ctrl = 24'h000013;
        b.imm  = 32'h10;
        b.src  = {32'h2, 32'h1};
        send(b);
        check("first_out_valid", out_valid, 1);
        check("first_pc", out_pc_plus_4, 32'h104);
        check("first_ctrl", out_ctrl, 24'h000013);
        check("first_imm", out_imm, 32'h10);
        check("first_src", out_src, 64'h0000_0002_0000_0001);
        out_ready = 1'b1;
        cycles(2);

        // Streaming
        base   = n_popped;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(mk(32'h100 + 32'(4 * i)));
            stalls += last_wait;
        end
        cycles(3);
        check("stream_in_ready_stalls", stalls, 0);
        check("stream_beats_out", n_popped - base, 8);
        check("stream_queue_empty", q.size(), 0);

        // Backpressure into the skid entry
        out_ready = 1'b0;
        base      = n_popped;
        send(mk(32'h200));
        send(mk(32'h204));
        drive(mk(32'h208));
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_pc_hold", out_pc_plus_4, 32'h200);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(mk(32'h208));
        cycles(4);
        check("bp_beats_out", n_popped - base, 3);
        check("bp_queue_empty", q.size(), 0);

        // Flush with both entries full and a beat offered
        out_ready = 1'b0;
        send(mk(32'h280));
        send(mk(32'h284));
        drive(mk(32'h300));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        check("flush_full_out_valid", out_valid, 0);
        check("flush_full_out_ctrl", out_ctrl, 0);
        check("flush_full_in_ready", in_ready, 1);

        // Flush with main full and in_ready high: the offered beat is dropped
        @(posedge clk);
        #1;
        send(mk(32'h380));
        drive(mk(32'h390));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        check("flush_accept_out_valid", out_valid, 0);
        check("flush_accept_out_ctrl", out_ctrl, 0);
        @(posedge clk);
        #1;
        base      = n_popped;
        out_ready = 1'b1;
        cycles(5);
        check("flush_nothing_emerges", n_popped - base, 0);
        send(mk(32'h3A0));
        cycles(3);
        check("after_flush_beats_out", n_popped - base, 1);
        check("after_flush_queue_empty", q.size(), 0);

        // Asynchronous reset between edges with both entries full
        out_ready = 1'b0;
        send(mk(32'h400));
        send(mk(32'h404));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_ctrl", out_ctrl, 0);
        check("async_rst_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        base      = n_popped;
        cycles(6);
        check("after_rst_no_beats", n_popped - base, 0);
        @(negedge clk);
        check("after_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

`ifdef IDEX_PERF_CNT_EN
        out_ready = 1'b0;
        send(mk(32'h500));
        cycles(5);
        check("perf_stall_cnt_5", stall_cnt, 5);
        out_ready = 1'b1;
        flush     = 1'b1;
        cycles(1);
        flush = 1'b0;
        send(mk(32'h504));
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        q.delete();
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        check("perf_stall_cnt_final", stall_cnt, 5);
        check("perf_flush_cnt", flush_cnt, 2);
`endif

        cycles(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
